// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic-array datapath: default array
// dimensions, accumulator/row types and the per-bank fill/drain state.
package systolic_pkg;

  localparam int DEF_N     = 8;
  localparam int DEF_ACC_W = 32;
  localparam int DEF_PTR_W = $clog2(DEF_N);

  typedef logic [DEF_ACC_W-1:0] acc_t;
  typedef acc_t [DEF_N-1:0]     row_t;

  // A bank either collects rows from the array or hands them to the consumer.
  typedef enum logic {
    BANK_FILL = 1'b0,
    BANK_FULL = 1'b1
  } bank_state_e;

endpackage

// File: rtl/c_row_bank.sv
// N-entry row register file: one synchronous write port and one
// combinational read port. Contents reset to zero.
module c_row_bank
  import systolic_pkg::*;
#(
  parameter  int N     = DEF_N,
  parameter  int ACC_W = DEF_ACC_W,
  localparam int PTR_W = $clog2(N),
  localparam int ROW_W = N * ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [ROW_W-1:0] wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [ROW_W-1:0] rd_data
);

  logic [ROW_W-1:0] mem_q [N];
  logic [ROW_W-1:0] mem_d [N];

  // Next storage contents: overwrite the addressed row when writing.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_data;
  end

  // Storage registers, zeroed on reset so the read port starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/c_drain_buffer.sv
// Output tile buffer behind the systolic array: captures N result rows per
// tile and streams them out on a valid/ready channel with a last-row flag.
// Define C_PINGPONG_EN to build with two banks so the next tile can fill
// while the current one drains; otherwise a single bank is used.
module c_drain_buffer
  import systolic_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               wr_en,
  input  logic [N*ACC_W-1:0] wr_row,
  output logic               wr_ready,
  output logic               c_valid,
  input  logic               c_ready,
  output logic [N*ACC_W-1:0] c_data,
  output logic               c_last,
  output logic               done,
  output logic               overflow
);

  localparam int               PTR_W    = $clog2(N);
  localparam logic [PTR_W-1:0] LAST_ROW = PTR_W'(N - 1);

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               overflow_q, overflow_d;
  logic               done_q, done_d;
  logic               wr_fire, rd_fire, wr_wrap, rd_wrap;
  logic [N*ACC_W-1:0] rd_data0;

`ifdef C_PINGPONG_EN
  logic               wr_bank_q, wr_bank_d;
  logic               rd_bank_q, rd_bank_d;
  bank_state_e        state_q [2];
  bank_state_e        state_d [2];
  logic [N*ACC_W-1:0] rd_data1;

  assign wr_ready = (state_q[wr_bank_q] == BANK_FILL);
  assign c_valid  = (state_q[rd_bank_q] == BANK_FULL);
  assign c_data   = rd_bank_q ? rd_data1 : rd_data0;
`else
  bank_state_e        state_q, state_d;

  assign wr_ready = (state_q == BANK_FILL);
  assign c_valid  = (state_q == BANK_FULL);
  assign c_data   = rd_data0;
`endif

  assign wr_fire  = wr_en && wr_ready;
  assign rd_fire  = c_valid && c_ready;
  assign wr_wrap  = wr_fire && (wr_ptr_q == LAST_ROW);
  assign rd_wrap  = rd_fire && (rd_ptr_q == LAST_ROW);
  assign c_last   = c_valid && (rd_ptr_q == LAST_ROW);
  assign done     = done_q;
  assign overflow = overflow_q;

  // Pointer, bank-state and flag updates; clear overrides writes and reads.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    state_d    = state_q;
`ifdef C_PINGPONG_EN
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
`endif
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
`ifdef C_PINGPONG_EN
      wr_bank_d  = 1'b0;
      rd_bank_d  = 1'b0;
      state_d[0] = BANK_FILL;
      state_d[1] = BANK_FILL;
`else
      state_d    = BANK_FILL;
`endif
    end else begin
      if (wr_en && !wr_ready) overflow_d = 1'b1;
      if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
      if (rd_wrap) done_d = 1'b1;
`ifdef C_PINGPONG_EN
      if (wr_wrap) begin
        state_d[wr_bank_q] = BANK_FULL;
        wr_bank_d          = ~wr_bank_q;
      end
      if (rd_wrap) begin
        state_d[rd_bank_q] = BANK_FILL;
        rd_bank_d          = ~rd_bank_q;
      end
`else
      if (wr_wrap) state_d = BANK_FULL;
      if (rd_wrap) state_d = BANK_FILL;
`endif
    end
  end

  // Control registers with asynchronous reset to an empty buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef C_PINGPONG_EN
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      state_q[0] <= BANK_FILL;
      state_q[1] <= BANK_FILL;
`else
      state_q    <= BANK_FILL;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      state_q    <= state_d;
`ifdef C_PINGPONG_EN
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
`endif
    end
  end

`ifdef C_PINGPONG_EN
  c_row_bank #(.N(N), .ACC_W(ACC_W)) u_bank0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_fire && !clear && !wr_bank_q),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_row),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data0)
  );

  c_row_bank #(.N(N), .ACC_W(ACC_W)) u_bank1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_fire && !clear && wr_bank_q),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_row),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data1)
  );
`else
  c_row_bank #(.N(N), .ACC_W(ACC_W)) u_bank0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_fire && !clear),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_row),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data0)
  );
`endif

endmodule
